vga_timing_dither: RTL and testbench

//  Parametrised VGA raster engine. It generates the h/v counters, the syncs, a frame counter

---
 rtl/vga_timing_dither_if.sv | 32 +++
 rtl/vga_timing_dither.sv | 130 +++++++++++++
 tb/tb_vga_timing_dither.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_dither_if.sv
// Bundle of the raster/pixel signals exchanged between the timing engine and
// the upstream pixel generators; the engine connects through the slave modport.
interface vga_timing_dither_if #(
    parameter int IN_BITS    = 6,
    parameter int OUT_BITS   = 2,
    parameter int FRAME_BITS = 11
);
    logic                    pause_n;
    logic [3*IN_BITS-1:0]    rgb_in;
    logic [10:0]             h_count;
    logic [9:0]              v_count;
    logic [FRAME_BITS-1:0]   frame;
    logic                    line_start;
    logic                    frame_start;
    logic                    hsync;
    logic                    vsync;
    logic [OUT_BITS-1:0]     r_out;
    logic [OUT_BITS-1:0]     g_out;
    logic [OUT_BITS-1:0]     b_out;

    modport master (
        output pause_n, rgb_in,
        input  h_count, v_count, frame, line_start, frame_start,
        input  hsync, vsync, r_out, g_out, b_out
    );

    modport slave (
        input  pause_n, rgb_in,
        output h_count, v_count, frame, line_start, frame_start,
        output hsync, vsync, r_out, g_out, b_out
    );
endinterface

// File: rtl/vga_timing_dither.sv
// VGA raster engine: h/v/frame counters, syncs and line/frame strobes, plus a
// one-clock output stage that Bayer-dithers the wide RGB stream to DAC width.
module vga_timing_dither #(
    parameter int H_DISPLAY  = 1220,
    parameter int H_FRONT    = 31,
    parameter int H_SYNC     = 183,
    parameter int H_BACK     = 92,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int IN_BITS    = 6,
    parameter int OUT_BITS   = 2,
    parameter int TEMPORAL   = 1,
    parameter int FRAME_BITS = 11
) (
    input  logic                clk48,
    input  logic                rst_n,
    vga_timing_dither_if.slave  vif
);
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DBITS    = IN_BITS - OUT_BITS;
    localparam int K        = DBITS / 2;
    localparam logic HS_ON  = (HSYNC_POL != 0);
    localparam logic VS_ON  = (VSYNC_POL != 0);
    localparam logic TEMP_EN = (TEMPORAL != 0);

    generate
        if (!(DBITS == 2 || DBITS == 4 || DBITS == 6)) begin : g_bad_dbits
            $error("vga_timing_dither: IN_BITS-OUT_BITS must be 2, 4 or 6");
        end
    endgenerate

    logic [10:0]           h_q, h_next;
    logic [9:0]            v_q, v_next;
    logic [FRAME_BITS-1:0] frame_q, frame_next;
    logic                  h_wrap, v_wrap;
    logic                  active, hs_act, vs_act;
    logic [K-1:0]          bx, by, bxy;
    logic [DBITS-1:0]      m_word, m_idx;

    logic                  line_start_q, frame_start_q, hsync_q, vsync_q;
    logic [OUT_BITS-1:0]   r_q, g_q, b_q;

    // Sum is one bit wider than the input so large values saturate instead of wrapping.
    function automatic logic [OUT_BITS-1:0] dither(input logic [IN_BITS-1:0] c,
                                                   input logic [DBITS-1:0]   m);
        logic [IN_BITS:0]  sum;
        logic [OUT_BITS:0] q;
        sum = {1'b0, c} + (IN_BITS+1)'(m);
        q   = sum[IN_BITS:DBITS];
        return q[OUT_BITS] ? {OUT_BITS{1'b1}} : q[OUT_BITS-1:0];
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        h_wrap     = (h_q == 11'(H_TOTAL - 1));
        v_wrap     = (v_q == 10'(V_TOTAL - 1));
        h_next     = h_wrap ? '0 : h_q + 11'd1;
        v_next     = v_q;
        frame_next = frame_q;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v_q + 10'd1;
            if (v_wrap)
                frame_next = frame_q + FRAME_BITS'(vif.pause_n);
        end

        active = (h_q < 11'(H_DISPLAY)) && (v_q < 10'(V_DISPLAY));
        hs_act = (h_q >= 11'(H_DISPLAY + H_FRONT)) &&
                 (h_q <  11'(H_DISPLAY + H_FRONT + H_SYNC));
        vs_act = (v_q >= 10'(V_DISPLAY + V_FRONT)) &&
                 (v_q <  10'(V_DISPLAY + V_FRONT + V_SYNC));

        // Bayer threshold: bit-reversed interleave of (x^y, x), MSB pair first.
        bx     = h_q[K-1:0] ^ {K{TEMP_EN & frame_q[0]}};
        by     = v_q[K-1:0];
        bxy    = bx ^ by;
        m_word = '0;
        m_idx  = '0;
        for (int i = 0; i < K; i++) begin
            m_word[2*i+1] = bxy[i];
            m_word[2*i]   = bx[i];
        end
        for (int i = 0; i < DBITS; i++)
            m_idx[i] = m_word[DBITS-1-i];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            frame_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
        end else begin
            h_q     <= h_next;
            v_q     <= v_next;
            frame_q <= frame_next;
            // Strobes are decoded from the next counter value so they line up with it.
            line_start_q  <= (h_next == 11'(H_DISPLAY));
            frame_start_q <= (h_next == '0) && (v_next == '0);
            hsync_q <= hs_act ? HS_ON : ~HS_ON;
            vsync_q <= vs_act ? VS_ON : ~VS_ON;
            r_q <= active ? dither(vif.rgb_in[3*IN_BITS-1 -: IN_BITS], m_idx) : '0;
            g_q <= active ? dither(vif.rgb_in[2*IN_BITS-1 -: IN_BITS], m_idx) : '0;
            b_q <= active ? dither(vif.rgb_in[IN_BITS-1:0], m_idx) : '0;
        end
    end

    assign vif.h_count     = h_q;
    assign vif.v_count     = v_q;
    assign vif.frame       = frame_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.r_out       = r_q;
    assign vif.g_out       = g_q;
    assign vif.b_out       = b_q;
endmodule

// File: tb/tb_vga_timing_dither.sv
// Directed bench: a default-timing engine for line timing and dither, plus two
// tiny-raster engines (temporal / 2-bit frame counter) for frame-level behaviour.
module tb_vga_timing_dither;
    logic clk48 = 1'b0;
    logic rst_n_def, rst_n_sm;
    int   total = 0;
    int   bad   = 0;
    int   fs_cnt = 0;
    bit   count_fs = 1'b0;
    int   lows;

    always #5 clk48 = ~clk48;

    vga_timing_dither_if #(.IN_BITS(6), .OUT_BITS(2), .FRAME_BITS(11)) def_if ();
    vga_timing_dither_if #(.IN_BITS(6), .OUT_BITS(2), .FRAME_BITS(11)) sm_if ();
    vga_timing_dither_if #(.IN_BITS(6), .OUT_BITS(2), .FRAME_BITS(2))  fb_if ();

    vga_timing_dither u_def (.clk48(clk48), .rst_n(rst_n_def), .vif(def_if.slave));

    // 16x8 raster: hsync on h 10..12, vsync on lines 5..6, 128 clocks per frame.
    vga_timing_dither #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .TEMPORAL(1), .FRAME_BITS(11)
    ) u_sm (.clk48(clk48), .rst_n(rst_n_sm), .vif(sm_if.slave));

    vga_timing_dither #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .TEMPORAL(0), .FRAME_BITS(2)
    ) u_fb (.clk48(clk48), .rst_n(rst_n_sm), .vif(fb_if.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk48);
            if (count_fs && sm_if.frame_start === 1'b1) fs_cnt++;
        end
    endtask

    // Drive one pixel on the default engine and check it one clock later.
    task automatic pix(input string tag, input logic [5:0] r, input logic [5:0] g,
                       input logic [5:0] b, input int er, input int eg, input int eb);
        def_if.rgb_in = {r, g, b};
        tick(1);
        check({tag, ".r"}, 32'(def_if.r_out), er);
        check({tag, ".g"}, 32'(def_if.g_out), eg);
        check({tag, ".b"}, 32'(def_if.b_out), eb);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_def      = 1'b0;
        rst_n_sm       = 1'b0;
        def_if.pause_n = 1'b1;
        def_if.rgb_in  = '0;
        sm_if.pause_n  = 1'b1;
        sm_if.rgb_in   = {6'd24, 6'd24, 6'd24};
        fb_if.pause_n  = 1'b1;
        fb_if.rgb_in   = {6'd24, 6'd24, 6'd24};

        tick(2);
        check("rst.h",     32'(def_if.h_count), 0);
        check("rst.v",     32'(def_if.v_count), 0);
        check("rst.frame", 32'(def_if.frame), 0);
        check("rst.hsync", 32'(def_if.hsync), 1);
        check("rst.vsync", 32'(def_if.vsync), 1);
        check("rst.fs",    32'(def_if.frame_start), 0);
        check("rst.r",     32'(def_if.r_out), 0);

        // Line 0 thresholds M = 0,12,3,15 for x = 0..3.
        rst_n_def = 1'b1;
        pix("l0x0", 6'd16, 6'd24, 6'd63, 1, 1, 3);
        pix("l0x1", 6'd16, 6'd24, 6'd63, 1, 2, 3);
        pix("l0x2", 6'd16, 6'd24, 6'd63, 1, 1, 3);
        pix("l0x3", 6'd16, 6'd24, 6'd63, 1, 2, 3);

        tick(1215);
        check("h1219", 32'(def_if.h_count), 1219);
        def_if.rgb_in = {6'd63, 6'd63, 6'd63};
        tick(1);
        check("ls.on",   32'(def_if.line_start), 1);
        check("last.r",  32'(def_if.r_out), 3);
        check("last.g",  32'(def_if.g_out), 3);
        tick(1);
        check("ls.off",  32'(def_if.line_start), 0);
        check("blank.r", 32'(def_if.r_out), 0);
        check("blank.g", 32'(def_if.g_out), 0);
        check("blank.b", 32'(def_if.b_out), 0);

        tick(30);
        check("hs.pre",  32'(def_if.hsync), 1);
        tick(1);
        check("hs.edge", 32'(def_if.hsync), 0);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (def_if.hsync === 1'b0) lows++;
            tick(1);
        end
        check("hs.width", 32'(lows), 183);

        tick(74);
        check("wrap.h", 32'(def_if.h_count), 0);
        check("wrap.v", 32'(def_if.v_count), 1);

        // Line 2 thresholds M = 1,13,2,14 for x = 0..3.
        tick(1526);
        pix("l2x0", 6'd30, 6'd20, 6'd0, 1, 1, 0);
        pix("l2x1", 6'd30, 6'd20, 6'd0, 2, 2, 0);
        pix("l2x2", 6'd30, 6'd20, 6'd0, 2, 1, 0);
        pix("l2x3", 6'd30, 6'd20, 6'd0, 2, 2, 0);

        tick(696);
        check("mid.h", 32'(def_if.h_count), 700);
        def_if.rgb_in = {6'd63, 6'd63, 6'd63};
        rst_n_def = 1'b0;
        tick(1);
        check("mrst.h",     32'(def_if.h_count), 0);
        check("mrst.v",     32'(def_if.v_count), 0);
        check("mrst.frame", 32'(def_if.frame), 0);
        check("mrst.r",     32'(def_if.r_out), 0);
        check("mrst.b",     32'(def_if.b_out), 0);
        check("mrst.hsync", 32'(def_if.hsync), 1);
        check("mrst.vsync", 32'(def_if.vsync), 1);
        rst_n_def = 1'b1;
        tick(1);
        check("mrst.h1", 32'(def_if.h_count), 1);

        // Tiny rasters: n counts clocks since reset release (frame = 128 clocks).
        rst_n_sm = 1'b1;
        count_fs = 1'b1;
        tick(1);
        check("sm.f0.r",  32'(sm_if.r_out), 1);
        check("fb.f0.r",  32'(fb_if.r_out), 1);
        check("sm.fs0",   32'(sm_if.frame_start), 0);
        tick(79);
        check("sm.v5",    32'(sm_if.v_count), 5);
        check("vs.pre",   32'(sm_if.vsync), 1);
        tick(1);
        check("vs.edge",  32'(sm_if.vsync), 0);
        tick(31);
        check("vs.v7",    32'(sm_if.v_count), 7);
        check("vs.last",  32'(sm_if.vsync), 0);
        tick(1);
        check("vs.post",  32'(sm_if.vsync), 1);
        tick(15);
        check("sm.fs1",   32'(sm_if.frame_start), 1);
        check("sm.f1",    32'(sm_if.frame), 1);
        check("sm.f1.h",  32'(sm_if.h_count), 0);
        tick(1);
        check("sm.fs1.w", 32'(sm_if.frame_start), 0);
        check("sm.f1.r",  32'(sm_if.r_out), 2);
        check("sm.f1.b",  32'(sm_if.b_out), 2);
        check("fb.f1.r",  32'(fb_if.r_out), 1);
        tick(255);
        check("sm.f3",    32'(sm_if.frame), 3);
        sm_if.pause_n = 1'b0;
        tick(128);
        check("sm.p4",    32'(sm_if.frame), 3);
        check("sm.fs4",   32'(sm_if.frame_start), 1);
        tick(128);
        check("sm.p5",    32'(sm_if.frame), 3);
        check("sm.fscnt", 32'(fs_cnt), 5);
        check("fb.wrap",  32'(fb_if.frame), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
